mem_stage_dm: RTL and testbench
===============================

// Module: mem_stage_dm
// PURPOSE
//  Data-memory responder for the M stage: consumes the address (ALUout_M), store data
//  (v_R2_M) and access type decoded from instrM, performs word/half/byte loads and
//  stores with fixed multi-cycle latency, and returns load data toward the W stage.
//  busy drives the hazard unit to freeze F/D/E/M while an access is outstanding.
// PARAMETERS
//  DEPTH_WORDS  3072  memory depth in 32-bit words (byte range 0 .. 4*DEPTH_WORDS-1)
//  LATENCY      2     cycles from request-accept edge to resp_valid; legal range 1..15
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  req_valid   in   1   M stage presents a load/store this cycle
//  req_we      in   1   1 = store, 0 = load
//  req_size    in   2   00 byte, 01 half, 10 word; 11 is illegal
//  req_signed  in   1   loads only: 1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu)
//  req_addr    in   32  byte address (ALUout_M)
//  req_wdata   in   32  store data, right-aligned (v_R2_M)
//  req_ready   out  1   1 only in IDLE; a request is accepted on req_valid & req_ready
//  busy        out  1   1 in BUSY and RESP
//  resp_valid  out  1   one-cycle pulse: access complete
//  resp_rdata  out  32  extended load data; 0 for stores and errors
//  resp_err    out  1   qualified by resp_valid: misaligned, out-of-range or size 11
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, counter=0, latched request cleared, resp_valid=0,
//   resp_rdata=0, resp_err=0, busy=0, req_ready=1 once reset deasserts. Memory array
//   is NOT cleared. A pending store is dropped (no write).
//  FSM: IDLE -> BUSY on accept. Latch we/size/signed/addr/wdata and set
//   counter=LATENCY-1. If LATENCY=1, go directly IDLE -> RESP.
//   BUSY: decrement counter each cycle; at counter==1 go to RESP.
//   RESP: resp_valid=1 for exactly one cycle, then IDLE.
//   resp_valid is high in the cycle that begins LATENCY edges after the accept edge.
//   Request inputs are ignored outside IDLE. No back-to-back accept: the request
//   following RESP is accepted no earlier than the first IDLE cycle.
//  Error check at accept: half with addr[0]!=0, word with addr[1:0]!=0, size==11,
//   or addr >= 4*DEPTH_WORDS. Error requests still take the full LATENCY.
//   They respond with resp_err=1 and resp_rdata=0, and never write memory.
//  Word index = latched_addr[31:2]. Byte lane = latched_addr[1:0]; half lane = addr[1].
//  Store: read-modify-write commits on the edge that enters RESP.
//   Byte enables: byte 0001<<addr[1:0]; half 0011 or 1100; word 1111.
//   The low 8/16 bits of wdata are replicated onto the selected lanes.
//  Load: the word is read on the edge entering RESP. The selected lane is shifted down
//   and extended per req_signed; word loads are returned unchanged.
//  resp_rdata and resp_err hold their values only while resp_valid=1 and return to 0
//   in the following cycle.
//  Reset asserted during BUSY or RESP: immediate IDLE; that access gives no resp_valid
//   and no write.
// TESTING
//  T1 sw 0x12345678 @0x10, then lw @0x10 (LATENCY=2): resp_valid 2 edges after each
//     accept; lw resp_rdata=0x12345678, resp_err=0.
//  T2 sb 0xAB @0x13 over word 0x12345678: word becomes 0xAB345678. lb @0x13 ->
//     0xFFFFFFAB; lbu @0x13 -> 0x000000AB.
//  T3 sh 0x8001 @0x22 over 0: word becomes 0x80010000. lh @0x22 -> 0xFFFF8001;
//     lhu -> 0x00008001.
//  T4 lw @0x11, sh @0x21, sw @0x3000 (DEPTH 3072): each gives resp_err=1,
//     resp_rdata=0; memory is unchanged on readback.
//  T5 req_valid held high continuously: req_ready=0 and busy=1 from the accept edge
//     through the RESP cycle. Exactly one response per accept; the next accept occurs
//     in IDLE. Repeat with LATENCY=1 (resp on the edge after accept).
//  T6 accept sw 0xDEADBEEF @0x40, then assert reset in the BUSY cycle: no resp_valid,
//     all outputs 0. After release, lw @0x40 returns the prior contents.

Source files
------------

// File: rtl/mem_stage_dm.sv
// rtl/mem_stage_dm.sv - M-stage data-memory responder with fixed multi-cycle latency
//
// Purpose:
//   Accepts one load/store at a time from the M stage. Stores are byte, half or
//   word sized. The access completes a fixed number of cycles after it is accepted.
//   Loads return their lane shifted down and sign- or zero-extended. Misaligned,
//   out-of-range or size-11 requests still take the full latency. They respond
//   with resp_err and never touch memory.
//
// Ports:
//   clk, reset               clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_size,        access type: store/load, 00 byte 01 half 10 word,
//   req_signed               sign-extend loads
//   req_addr, req_wdata      byte address, right-aligned store data
//   busy                     freezes F/D/E/M while an access is outstanding
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_err     extended load data / error flag, zero outside resp_valid

module mem_stage_dm #(
  parameter int DEPTH_WORDS = 3072,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam int          AW         = IDX_W + 2;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1     = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;

  logic          lat_we;
  logic [1:0]    lat_size;
  logic          lat_signed;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic          lat_err;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          commit;
  logic          in_err;
  logic          op_we;
  logic [1:0]    op_size;
  logic          op_signed;
  logic [AW-1:0] op_addr;
  logic [31:0]   op_wdata;
  logic          op_err;
  logic [IDX_W-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic [3:0]    be;
  logic [31:0]   wrep;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;

  assign accept = (state == S_IDLE) && req_valid;

  always_comb begin
    in_err = 1'b0;
    case (req_size)
      2'b01:   in_err = req_addr[0];
      2'b10:   in_err = |req_addr[1:0];
      2'b11:   in_err = 1'b1;
      default: in_err = 1'b0;
    endcase
    if (req_addr >= ADDR_LIMIT) in_err = 1'b1;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          cnt_n   = LAT_M1;
          state_n = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = S_RESP;
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Memory is touched on the edge that enters RESP. With LATENCY=1 that edge is
  // the accept edge itself, so the live request is used instead of the latch.
  assign commit = reset && (state != S_RESP) && (state_n == S_RESP);

  always_comb begin
    if (state == S_IDLE) begin
      op_we     = req_we;
      op_size   = req_size;
      op_signed = req_signed;
      op_addr   = req_addr[AW-1:0];
      op_wdata  = req_wdata;
      op_err    = in_err;
    end else begin
      op_we     = lat_we;
      op_size   = lat_size;
      op_signed = lat_signed;
      op_addr   = lat_addr;
      op_wdata  = lat_wdata;
      op_err    = lat_err;
    end
  end

  assign idx     = op_addr[AW-1:2];
  assign lane    = op_addr[1:0];
  assign rd_word = mem[idx];

  always_comb begin
    be   = 4'b1111;
    wrep = op_wdata;
    case (op_size)
      2'b00: begin
        be   = 4'b0001 << lane;
        wrep = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wrep = {2{op_wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = op_wdata;
      end
    endcase
  end

  always_comb begin
    byte_sel = rd_word[7:0];
    case (lane)
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (op_size)
      2'b00:   load_data = op_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      2'b01:   load_data = op_signed ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // Array has no reset: contents survive reset, only in-flight stores are dropped.
  always_ff @(posedge clk) begin
    if (commit && op_we && !op_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_size   <= 2'b00;
      lat_signed <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= 32'd0;
      lat_err    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        lat_we     <= req_we;
        lat_size   <= req_size;
        lat_signed <= req_signed;
        lat_addr   <= req_addr[AW-1:0];
        lat_wdata  <= req_wdata;
        lat_err    <= in_err;
      end
    end
  end

  // Response data lives only for the RESP cycle; any other edge clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (commit) begin
      resp_err   <= op_err;
      resp_rdata <= (op_err || op_we) ? 32'd0 : load_data;
    end else begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_RESP);

endmodule

// File: tb/tb_mem_stage_dm.sv
// tb/tb_mem_stage_dm.sv - randomized self-checking bench for mem_stage_dm (LATENCY 2 and 1)

module tb_mem_stage_dm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rv [2];
  logic        we [2];
  logic [1:0]  sz [2];
  logic        sg [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic        rdy [2];
  logic        bsy [2];
  logic        vld [2];
  logic [31:0] rd [2];
  logic        er [2];

  int checks = 0;
  int errors = 0;

  // Reference memory: only the first 64 words are ever legally accessed.
  logic [31:0] mdl [2][64];

  mem_stage_dm #(.DEPTH_WORDS(3072), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(rv[0]), .req_we(we[0]), .req_size(sz[0]), .req_signed(sg[0]),
    .req_addr(ad[0]), .req_wdata(wd[0]),
    .req_ready(rdy[0]), .busy(bsy[0]), .resp_valid(vld[0]),
    .resp_rdata(rd[0]), .resp_err(er[0])
  );

  mem_stage_dm #(.DEPTH_WORDS(3072), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(rv[1]), .req_we(we[1]), .req_size(sz[1]), .req_signed(sg[1]),
    .req_addr(ad[1]), .req_wdata(wd[1]),
    .req_ready(rdy[1]), .busy(bsy[1]), .resp_valid(vld[1]),
    .resp_rdata(rd[1]), .resp_err(er[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic model(input int d, input logic w, input logic [1:0] s, input logic g,
                       input logic [31:0] a, input logic [31:0] dat,
                       output logic [31:0] erd, output logic eerr);
    int sh;
    logic [31:0] word;
    logic [31:0] v;
    eerr = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) ||
           (a >= 32'd12288);
    erd = 32'd0;
    if (!eerr) begin
      word = mdl[d][a[7:2]];
      sh   = 8 * int'(a[1:0]);
      if (w) begin
        case (s)
          2'd0:    word = (word & ~(32'hFF << sh)) | ((dat & 32'hFF) << sh);
          2'd1:    word = (word & ~(32'hFFFF << sh)) | ((dat & 32'hFFFF) << sh);
          default: word = dat;
        endcase
        mdl[d][a[7:2]] = word;
      end else begin
        case (s)
          2'd0: begin
            v = (word >> sh) & 32'hFF;
            if (g && v >= 32'd128) v = v - 32'd256;
          end
          2'd1: begin
            v = (word >> sh) & 32'hFFFF;
            if (g && v >= 32'd32768) v = v - 32'd65536;
          end
          default: v = word;
        endcase
        erd = v;
      end
    end
  endtask

  // Presents one request in an IDLE cycle, keeps req_valid high throughout, and
  // scribbles on the other request inputs while busy to show they are ignored.
  task automatic do_req(input int d, input logic w, input logic [1:0] s, input logic g,
                        input logic [31:0] a, input logic [31:0] dat,
                        output logic [31:0] grd, output logic gerr);
    logic [31:0] erd;
    logic        eerr;
    grd  = 32'd0;
    gerr = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(rdy[d]), 32'd1);
    check("idle_busy",  32'(bsy[d]), 32'd0);
    check("idle_valid", 32'(vld[d]), 32'd0);
    check("idle_rdata", rd[d], 32'd0);
    check("idle_err",   32'(er[d]), 32'd0);
    rv[d] = 1'b1; we[d] = w; sz[d] = s; sg[d] = g; ad[d] = a; wd[d] = dat;
    model(d, w, s, g, a, dat, erd, eerr);
    @(posedge clk);
    for (int k = 0; k < lat_of(d); k++) begin
      @(negedge clk);
      check("busy_high", 32'(bsy[d]), 32'd1);
      check("ready_low", 32'(rdy[d]), 32'd0);
      if (k < lat_of(d) - 1) begin
        check("early_valid", 32'(vld[d]), 32'd0);
        we[d] = 1'($urandom_range(0, 1));
        sz[d] = 2'($urandom_range(0, 3));
        ad[d] = $urandom;
        wd[d] = $urandom;
      end else begin
        check("resp_valid", 32'(vld[d]), 32'd1);
        check("resp_rdata", rd[d], erd);
        check("resp_err",   32'(er[d]), 32'(eerr));
        grd  = rd[d];
        gerr = er[d];
      end
    end
  endtask

  initial begin
    logic [31:0] grd;
    logic        gerr;
    logic [31:0] a;
    logic [1:0]  s;
    int          r;

    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; we[d] = 1'b0; sz[d] = 2'd0; sg[d] = 1'b0; ad[d] = 32'd0; wd[d] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", 32'(vld[d]), 32'd0);
      check("rst_busy",  32'(bsy[d]), 32'd0);
      check("rst_rdata", rd[d], 32'd0);
      check("rst_err",   32'(er[d]), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check("rst_ready", 32'(rdy[d]), 32'd1);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) do_req(d, 1'b1, 2'd2, 1'b0, 32'(i * 4), 32'd0, grd, gerr);

      do_req(d, 1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678, grd, gerr);
      do_req(d, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, grd, gerr);
      check("t1_lw", grd, 32'h12345678);
      check("t1_err", 32'(gerr), 32'd0);

      do_req(d, 1'b1, 2'd0, 1'b0, 32'h13, 32'h000000AB, grd, gerr);
      do_req(d, 1'b0, 2'd0, 1'b1, 32'h13, 32'd0, grd, gerr);
      check("t2_lb", grd, 32'hFFFFFFAB);
      do_req(d, 1'b0, 2'd0, 1'b0, 32'h13, 32'd0, grd, gerr);
      check("t2_lbu", grd, 32'h000000AB);
      do_req(d, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, grd, gerr);
      check("t2_lw", grd, 32'hAB345678);

      do_req(d, 1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, grd, gerr);
      do_req(d, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, grd, gerr);
      check("t3_lw", grd, 32'h80010000);
      do_req(d, 1'b0, 2'd1, 1'b1, 32'h22, 32'd0, grd, gerr);
      check("t3_lh", grd, 32'hFFFF8001);
      do_req(d, 1'b0, 2'd1, 1'b0, 32'h22, 32'd0, grd, gerr);
      check("t3_lhu", grd, 32'h00008001);

      do_req(d, 1'b0, 2'd2, 1'b0, 32'h11, 32'd0, grd, gerr);
      check("t4_lw_mis_err", 32'(gerr), 32'd1);
      check("t4_lw_mis_rd", grd, 32'd0);
      do_req(d, 1'b1, 2'd1, 1'b0, 32'h21, 32'hFFFF, grd, gerr);
      check("t4_sh_mis_err", 32'(gerr), 32'd1);
      do_req(d, 1'b1, 2'd2, 1'b0, 32'h3000, 32'hFFFFFFFF, grd, gerr);
      check("t4_sw_oor_err", 32'(gerr), 32'd1);
      do_req(d, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, grd, gerr);
      check("t4_rb10", grd, 32'hAB345678);
      do_req(d, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, grd, gerr);
      check("t4_rb20", grd, 32'h80010000);

      for (int n = 0; n < 150; n++) begin
        r = $urandom_range(0, 19);
        s = (r == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        a = 32'($urandom_range(0, 255));
        if (r >= 3) begin
          if (s == 2'd1) a[0] = 1'b0;
          if (s == 2'd2) a[1:0] = 2'b00;
        end
        if (r == 1) a = 32'h3000 + 32'($urandom_range(0, 4095));
        if (r == 2) a = 32'h80000000 | $urandom;
        do_req(d, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom, grd, gerr);
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          rv[d] = 1'b0;
          check("gap_valid", 32'(vld[d]), 32'd0);
        end
      end
      @(negedge clk);
      rv[d] = 1'b0;
    end

    // Reset during BUSY drops the pending store and its response.
    @(negedge clk);
    rv[0] = 1'b1; we[0] = 1'b1; sz[0] = 2'd2; sg[0] = 1'b0; ad[0] = 32'h40; wd[0] = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    check("t6_busy", 32'(bsy[0]), 32'd1);
    reset = 1'b0;
    rv[0] = 1'b0;
    #1;
    check("t6_rst_valid", 32'(vld[0]), 32'd0);
    check("t6_rst_busy",  32'(bsy[0]), 32'd0);
    check("t6_rst_rdata", rd[0], 32'd0);
    check("t6_rst_err",   32'(er[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t6_hold_valid", 32'(vld[0]), 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_post_valid", 32'(vld[0]), 32'd0);
      check("t6_post_busy",  32'(bsy[0]), 32'd0);
    end
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, grd, gerr);
    check("t6_no_write", 32'(grd == 32'hDEADBEEF), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
